// File: rtl/credit_pkg.sv
// Shared types and default sizing for the credit sender arbiter.
package credit_pkg;

   // Sender link state: resynchronising, transmitting, or credit-withheld
   typedef enum logic [1:0] {
      ST_SYNC = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   localparam int DEF_NUM_REQ     = 4;
   localparam int DEF_DATA_WIDTH  = 8;
   localparam int DEF_MAX_CREDITS = 8;

endpackage

// File: rtl/credit_sender_arbiter_if.sv
// Requester-side handshake and outbound link beat, bundled for the arbiter.
interface credit_sender_arbiter_if
   import credit_pkg::*;
#(
   parameter int NUM_REQ    = DEF_NUM_REQ,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();
   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_ready;
   logic                          push_valid;
   logic [DATA_WIDTH-1:0]         push_data;
   logic [IW-1:0]                 grant_id;

   // Arbiter side: consumes requests, produces grants and link beats
   modport slave (
      input  req_valid, req_data,
      output req_ready, push_valid, push_data, grant_id
   );

   // Requester/environment side
   modport master (
      output req_valid, req_data,
      input  req_ready, push_valid, push_data, grant_id
   );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin selector: first asserted request at or after the pointer wins.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IW      = 2
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IW-1:0]      i_ptr,
   output logic [NUM_REQ-1:0] o_gnt,
   output logic [IW-1:0]      o_gnt_idx,
   output logic               o_any
);

   // Scan from the pointer upward with wrap, latching onto the first hit
   always_comb begin
      int            v_idx;
      logic [IW-1:0] v_sel;
      o_gnt     = {NUM_REQ{1'b0}};
      o_gnt_idx = {IW{1'b0}};
      o_any     = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         v_idx = int'(i_ptr) + k;
         if (v_idx >= NUM_REQ) begin
            v_idx = v_idx - NUM_REQ;
         end else begin
            v_idx = v_idx;
         end
         v_sel = IW'(v_idx);
         if (!o_any && i_req[v_sel]) begin
            o_gnt[v_sel] = 1'b1;
            o_gnt_idx    = v_sel;
            o_any        = 1'b1;
         end else begin
            o_any = o_any;
         end
      end
   end

endmodule

// File: rtl/credit_sender_arbiter.sv
// Credit-based link sender: round-robin arbitration of NUM_REQ requesters
// onto one registered link, gated by a saturating credit counter and a
// SYNC/RUN/HOLD link-state machine.
module credit_sender_arbiter
   import credit_pkg::*;
#(
   parameter int NUM_REQ     = DEF_NUM_REQ,
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int MAX_CREDITS = DEF_MAX_CREDITS
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               push_receiver_in_reset,
   output logic                               push_sender_in_reset,
   input  logic                               push_credit,
   output logic                               push_credit_stall,
   input  logic                               credit_withhold,
   output logic [$clog2(MAX_CREDITS+1)-1:0]   credit_count,
   output logic                               credit_overflow,
   credit_sender_arbiter_if.slave             bus
);
   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = $clog2(MAX_CREDITS + 1);
   localparam logic [CW-1:0] MAX_CNT   = CW'(MAX_CREDITS);
   localparam logic [CW-1:0] STALL_CNT = CW'(MAX_CREDITS - 1);
   localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_REQ - 1);

   state_t                r_state;
   logic [CW-1:0]         r_credit_count;
   logic [IW-1:0]         r_rr_ptr;
   logic                  r_push_valid;
   logic [DATA_WIDTH-1:0] r_push_data;
   logic [IW-1:0]         r_grant_id;
   logic                  r_credit_overflow;

   logic                  w_grant_en;
   logic [NUM_REQ-1:0]    w_arb_req;
   logic [NUM_REQ-1:0]    w_grant;
   logic [IW-1:0]         w_grant_idx;
   logic                  w_accept;
   logic [CW-1:0]         w_credit_next;
   logic                  w_overflow_hit;
   logic [IW-1:0]         w_rr_next;
   logic [DATA_WIDTH-1:0] w_sel_data;

   // Grants need RUN and at least one credit already held (no same-cycle bypass)
   assign w_grant_en = (r_state == ST_RUN) && (r_credit_count != {CW{1'b0}});
   assign w_arb_req  = bus.req_valid & {NUM_REQ{w_grant_en}};

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IW      (IW)
   ) u_rr_arbiter (
      .i_req     (w_arb_req),
      .i_ptr     (r_rr_ptr),
      .o_gnt     (w_grant),
      .o_gnt_idx (w_grant_idx),
      .o_any     (w_accept)
   );

   assign w_rr_next = (w_grant_idx == LAST_IDX) ? {IW{1'b0}} : (w_grant_idx + IW'(1));

   // Mux the granted requester's payload with an AND-OR tree over the one-hot grant
   always_comb begin
      w_sel_data = {DATA_WIDTH{1'b0}};
      for (int i = 0; i < NUM_REQ; i++) begin
         w_sel_data = w_sel_data |
                      (bus.req_data[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{w_grant[i]}});
      end
   end

   // Next credit value: a returned credit and a spent credit cancel out
   always_comb begin
      w_credit_next  = r_credit_count;
      w_overflow_hit = 1'b0;
      if (push_credit && !w_accept) begin
         if (r_credit_count == MAX_CNT) begin
            w_overflow_hit = 1'b1;
         end else begin
            w_credit_next = r_credit_count + CW'(1);
         end
      end else if (!push_credit && w_accept) begin
         w_credit_next = r_credit_count - CW'(1);
      end else begin
         w_credit_next = r_credit_count;
      end
   end

   // Link FSM, credit counter, round-robin pointer and registered link beat
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state           <= ST_SYNC;
         r_credit_count    <= {CW{1'b0}};
         r_rr_ptr          <= {IW{1'b0}};
         r_push_valid      <= 1'b0;
         r_push_data       <= {DATA_WIDTH{1'b0}};
         r_grant_id        <= {IW{1'b0}};
         r_credit_overflow <= 1'b0;
      end else begin
         // A beat accepted this cycle always issues, even if the link drops to SYNC
         r_push_valid <= w_accept;
         if (w_accept) begin
            r_push_data <= w_sel_data;
            r_grant_id  <= w_grant_idx;
            r_rr_ptr    <= w_rr_next;
         end
         if (w_overflow_hit) begin
            r_credit_overflow <= 1'b1;
         end
         case (r_state)
            ST_SYNC: begin
               r_credit_count <= {CW{1'b0}};
               if (!push_receiver_in_reset) begin
                  r_state <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (push_receiver_in_reset) begin
                  r_state        <= ST_SYNC;
                  r_credit_count <= {CW{1'b0}};
               end else begin
                  r_credit_count <= w_credit_next;
                  if (credit_withhold) begin
                     r_state <= ST_HOLD;
                  end
               end
            end
            ST_HOLD: begin
               if (push_receiver_in_reset) begin
                  r_state        <= ST_SYNC;
                  r_credit_count <= {CW{1'b0}};
               end else begin
                  r_credit_count <= w_credit_next;
                  if (!credit_withhold) begin
                     r_state <= ST_RUN;
                  end
               end
            end
            default: begin
               r_state        <= ST_SYNC;
               r_credit_count <= {CW{1'b0}};
            end
         endcase
      end
   end

   assign push_sender_in_reset = (r_state == ST_SYNC);
   assign push_credit_stall    = (r_state == ST_RUN) && (r_credit_count >= STALL_CNT) && !w_accept;
   assign credit_count         = r_credit_count;
   assign credit_overflow      = r_credit_overflow;

   assign bus.req_ready  = w_grant;
   assign bus.push_valid = r_push_valid;
   assign bus.push_data  = r_push_data;
   assign bus.grant_id   = r_grant_id;

endmodule

// File: tb/tb_credit_sender_arbiter.sv
// Directed scoreboard bench for credit_sender_arbiter (4 requesters, 8-bit, 8 credits).
module tb_credit_sender_arbiter;
   import credit_pkg::*;

   logic       clk;
   logic       rst_n;
   logic       rx_in_reset;
   logic       tx_in_reset;
   logic       credit;
   logic       stall;
   logic       withhold;
   logic [3:0] count;
   logic       overflow;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [1:0] id;
      logic [7:0] data;
   } beat_t;
   beat_t exp_q[$];

   credit_sender_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8)) bus ();

   credit_sender_arbiter #(
      .NUM_REQ     (4),
      .DATA_WIDTH  (8),
      .MAX_CREDITS (8)
   ) dut (
      .clk                    (clk),
      .rst_n                  (rst_n),
      .push_receiver_in_reset (rx_in_reset),
      .push_sender_in_reset   (tx_in_reset),
      .push_credit            (credit),
      .push_credit_stall      (stall),
      .credit_withhold        (withhold),
      .credit_count           (count),
      .credit_overflow        (overflow),
      .bus                    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic probe();
      @(negedge clk);
   endtask

   task automatic set_data(input logic [7:0] base);
      for (int i = 0; i < 4; i++) begin
         bus.req_data[i*8 +: 8] = base + 8'(i);
      end
   endtask

   task automatic expect_beat(input int id, input logic [7:0] base);
      beat_t b;
      b.id   = 2'(id);
      b.data = base + 8'(id);
      exp_q.push_back(b);
   endtask

   // Monitor: every link beat must match the oldest outstanding expectation
   always @(negedge clk) begin
      beat_t e;
      if (bus.push_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL beat_unexpected actual id=%0d data=%0h required=no beat",
                     bus.grant_id, bus.push_data);
         end else begin
            e = exp_q.pop_front();
            check("beat_id", 32'(bus.grant_id), 32'(e.id));
            check("beat_data", 32'(bus.push_data), 32'(e.data));
         end
      end
   end

   // Watchdog
   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; rx_in_reset = 1'b1; credit = 1'b0; withhold = 1'b0;
      bus.req_valid = 4'h0; bus.req_data = 32'h0;
      repeat (2) tick();
      probe();
      check("rst_tx_in_reset", 32'(tx_in_reset), 32'd1);
      check("rst_count", 32'(count), 32'd0);
      check("rst_push_valid", 32'(bus.push_valid), 32'd0);
      check("rst_push_data", 32'(bus.push_data), 32'd0);
      check("rst_grant_id", 32'(bus.grant_id), 32'd0);
      check("rst_ready", 32'(bus.req_ready), 32'd0);
      check("rst_stall", 32'(stall), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      tick();

      // SYNC ignores credits while receiver stays in reset
      rst_n = 1'b1; credit = 1'b1;
      probe(); tick();
      rx_in_reset = 1'b0; credit = 1'b0;
      probe();
      check("sync_count", 32'(count), 32'd0);
      check("sync_tx_in_reset", 32'(tx_in_reset), 32'd1);
      tick();

      // Three credits, all requesters valid: grants 0,1,2 then dry
      credit = 1'b1;
      probe();
      check("run_tx_in_reset", 32'(tx_in_reset), 32'd0);
      check("run_count0", 32'(count), 32'd0);
      tick(); tick(); tick();
      credit = 1'b0; bus.req_valid = 4'hF; set_data(8'h10);
      for (int k = 0; k < 3; k++) begin
         expect_beat(k, 8'h10);
         probe();
         check("rr_ready", 32'(bus.req_ready), 32'(4'b0001 << k));
         check("rr_count", 32'(count), 32'(3 - k));
         check("rr_stall", 32'(stall), 32'd0);
         tick();
      end
      probe();
      check("dry_ready", 32'(bus.req_ready), 32'd0);
      check("dry_count", 32'(count), 32'd0);
      tick();

      // Credit at zero is not usable in the same cycle
      bus.req_valid = 4'b0010; credit = 1'b1; set_data(8'h20);
      probe();
      check("bypass_ready", 32'(bus.req_ready), 32'd0);
      tick();
      credit = 1'b0; expect_beat(1, 8'h20);
      probe();
      check("late_ready", 32'(bus.req_ready), 32'b0010);
      check("late_count", 32'(count), 32'd1);
      tick();
      bus.req_valid = 4'h0;
      probe();
      check("late_count_after", 32'(count), 32'd0);
      tick();

      // Credit in and accept in the same cycle cancel
      credit = 1'b1;
      tick(); tick();
      bus.req_valid = 4'b0001; set_data(8'h30); expect_beat(0, 8'h30);
      probe();
      check("both_ready", 32'(bus.req_ready), 32'b0001);
      check("both_count_before", 32'(count), 32'd2);
      tick();
      credit = 1'b0; bus.req_valid = 4'h0;
      probe();
      check("both_count_after", 32'(count), 32'd2);
      tick();

      // Fill to the ceiling, watch stall, then overflow
      credit = 1'b1;
      for (int k = 0; k < 6; k++) begin
         probe();
         check("fill_count", 32'(count), 32'(2 + k));
         check("fill_stall", 32'(stall), (2 + k >= 7) ? 32'd1 : 32'd0);
         tick();
      end
      probe();
      check("full_count", 32'(count), 32'd8);
      check("full_stall", 32'(stall), 32'd1);
      check("full_overflow_pre", 32'(overflow), 32'd0);
      tick();
      credit = 1'b0;
      probe();
      check("sat_count", 32'(count), 32'd8);
      check("sat_overflow", 32'(overflow), 32'd1);
      tick();

      // Drain to 4 from rr_ptr=1: grants 1,2,3,0; stall drops while accepting
      bus.req_valid = 4'hF; set_data(8'h40);
      for (int k = 0; k < 4; k++) begin
         expect_beat((k + 1) % 4, 8'h40);
         probe();
         check("drain_ready", 32'(bus.req_ready), 32'(4'b0001 << ((k + 1) % 4)));
         check("drain_count", 32'(count), 32'(8 - k));
         check("drain_stall", 32'(stall), 32'd0);
         tick();
      end

      // Accept at 4 credits, then receiver enters reset
      bus.req_valid = 4'b0100; set_data(8'h50); expect_beat(2, 8'h50);
      probe();
      check("pre_sync_ready", 32'(bus.req_ready), 32'b0100);
      check("pre_sync_count", 32'(count), 32'd4);
      tick();
      bus.req_valid = 4'h0; rx_in_reset = 1'b1;
      probe();
      check("pre_sync_count2", 32'(count), 32'd3);
      tick();
      bus.req_valid = 4'hF; credit = 1'b1;
      for (int k = 0; k < 2; k++) begin
         probe();
         check("sync_ready", 32'(bus.req_ready), 32'd0);
         check("sync_tx", 32'(tx_in_reset), 32'd1);
         check("sync_cleared", 32'(count), 32'd0);
         check("sync_stall", 32'(stall), 32'd0);
         tick();
      end
      rx_in_reset = 1'b0; bus.req_valid = 4'h0; credit = 1'b0;
      probe();
      check("overflow_sticky", 32'(overflow), 32'd1);
      tick();

      // Withhold with 2 credits: no grants, credits counted, resume at rr_ptr=3
      credit = 1'b1;
      tick(); tick();
      credit = 1'b0; withhold = 1'b1;
      probe();
      check("wh_count_entry", 32'(count), 32'd2);
      tick();
      bus.req_valid = 4'hF; set_data(8'h60); credit = 1'b1;
      probe();
      check("hold_ready", 32'(bus.req_ready), 32'd0);
      check("hold_stall", 32'(stall), 32'd0);
      check("hold_count", 32'(count), 32'd2);
      tick();
      credit = 1'b0;
      probe();
      check("hold_count_inc", 32'(count), 32'd3);
      check("hold_ready2", 32'(bus.req_ready), 32'd0);
      tick();
      withhold = 1'b0;
      probe();
      check("hold_exit_ready", 32'(bus.req_ready), 32'd0);
      tick();
      for (int k = 0; k < 3; k++) begin
         expect_beat((k + 3) % 4, 8'h60);
         probe();
         check("resume_ready", 32'(bus.req_ready), 32'(4'b0001 << ((k + 3) % 4)));
         check("resume_count", 32'(count), 32'(3 - k));
         tick();
      end
      probe();
      check("resume_dry_ready", 32'(bus.req_ready), 32'd0);
      check("resume_dry_count", 32'(count), 32'd0);
      tick();
      bus.req_valid = 4'h0;
      repeat (3) tick();
      check("beats_outstanding", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
